// File: rtl/wb_rr_arbiter_pkg.sv
// wb_arb_pkg: shared Wishbone widths, arbiter FSM states and CTI codes.
package wb_arb_pkg;
  localparam int WB_ADR_W = 30;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int WB_CTI_W = 3;
  localparam int WB_BTE_W = 2;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  localparam logic [WB_CTI_W-1:0] CLASSIC = 3'b000;
  localparam logic [WB_CTI_W-1:0] INC_BURST = 3'b010;
  localparam logic [WB_CTI_W-1:0] END_OF_BURST = 3'b111;
endpackage

// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: Wishbone B4 bundle for N ports packed side by side.
// Port i occupies slice [i*W +: W] of every field.
// master: drives address/data/controls, receives dat_r/ack/err.
// slave:  receives address/data/controls, drives dat_r/ack/err.
interface wb_rr_arbiter_if #(parameter int N = 1);
  import wb_arb_pkg::*;
  logic [N*WB_ADR_W-1:0] adr;
  logic [N*WB_DAT_W-1:0] dat_w;
  logic [N*WB_DAT_W-1:0] dat_r;
  logic [N*WB_SEL_W-1:0] sel;
  logic [N-1:0] we;
  logic [N-1:0] cyc;
  logic [N-1:0] stb;
  logic [N*WB_CTI_W-1:0] cti;
  logic [N*WB_BTE_W-1:0] bte;
  logic [N-1:0] ack;
  logic [N-1:0] err;
  modport master (output adr, dat_w, sel, we, cyc, stb, cti, bte, input dat_r, ack, err);
  modport slave (input adr, dat_w, sel, we, cyc, stb, cti, bte, output dat_r, ack, err);
endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first requester above last.
// req: request vector; last: previous winner index (lowest priority).
// win: one-hot winner (zero if no request); idx: winner index.
module rr_pick #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);
  // Scan from farthest to nearest so the nearest requester above last ends up kept.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N; k > 0; k--)
      if (req[(int'(last) + k) % N]) begin
        idx = IW'((int'(last) + k) % N);
        win = '0;
        win[(int'(last) + k) % N] = 1'b1;
      end
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone B4 arbiter with a stall watchdog.
// clk/reset: clock and synchronous active-high reset.
// m_wishbone: NUM_MASTERS requesting masters; wishbone: the single slave port.
// grant: registered one-hot owner; timeout: registered pulse after a watchdog abort.
module wb_rr_arbiter import wb_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  wb_rr_arbiter_if.slave m_wishbone,
  wb_rr_arbiter_if.master wishbone,
  output logic [NUM_MASTERS-1:0] grant,
  output logic timeout
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(TIMEOUT);
  state_t state, state_n;
  logic [NUM_MASTERS-1:0] grant_n, win;
  logic [IW-1:0] last, last_n, own, own_n, win_idx;
  logic [TW-1:0] wd, wd_n;
  logic busy, g_cyc, g_stb, stall, abort;
  rr_pick #(.N(NUM_MASTERS)) u_pick (.req(m_wishbone.cyc), .last(last), .win(win), .idx(win_idx));
  assign busy = state == BUSY;
  assign g_cyc = |(m_wishbone.cyc & grant);
  assign g_stb = |(m_wishbone.stb & grant);
  assign stall = busy && g_cyc && g_stb && !wishbone.ack && !wishbone.err;
  // Abort lands on the TIMEOUT-th stalled cycle; an ack/err that same cycle clears stall and wins.
  assign abort = stall && wd == TW'(TIMEOUT - 1);
  assign wishbone.adr = m_wishbone.adr[own*WB_ADR_W +: WB_ADR_W];
  assign wishbone.dat_w = m_wishbone.dat_w[own*WB_DAT_W +: WB_DAT_W];
  assign wishbone.sel = m_wishbone.sel[own*WB_SEL_W +: WB_SEL_W];
  assign wishbone.we = m_wishbone.we[own];
  assign wishbone.cti = m_wishbone.cti[own*WB_CTI_W +: WB_CTI_W];
  assign wishbone.bte = m_wishbone.bte[own*WB_BTE_W +: WB_BTE_W];
  assign wishbone.cyc = busy && g_cyc;
  assign wishbone.stb = busy && g_cyc && g_stb;
  assign m_wishbone.dat_r = {NUM_MASTERS{wishbone.dat_r}};
  assign m_wishbone.ack = {NUM_MASTERS{busy && wishbone.ack}} & grant;
  assign m_wishbone.err = {NUM_MASTERS{busy && (wishbone.err || abort)}} & grant;
  always_comb begin
    state_n = state;
    grant_n = grant;
    own_n = own;
    last_n = last;
    if (state == IDLE && |m_wishbone.cyc) begin
      state_n = BUSY;
      grant_n = win;
      own_n = win_idx;
      last_n = win_idx;
    end else if (state != IDLE && !g_cyc) begin
      state_n = IDLE;
      grant_n = '0;
    end else if (abort) state_n = DRAIN;
    wd_n = (stall && state_n == BUSY) ? wd + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last <= IW'(NUM_MASTERS - 1);
      own <= '0;
      wd <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last <= last_n;
      own <= own_n;
      wd <= wd_n;
      timeout <= abort;
    end
  end
endmodule
